// File: rtl/nareg_skid.sv
// nareg_skid: valid/ready holding register with a one-entry skid buffer (or plain always-load register when BYPASS=1).
// Latency: one cycle from in_fire to out_valid/out_data; one transfer per cycle sustained.
// Backpressure: in_ready drops only when both entries are held; it is a flop, so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   flush           synchronous clear of buffered contents (data registers keep their values)
//   in_valid/in_ready/in_data     producer handshake
//   out_valid/out_ready/out_data  consumer handshake; out_data is always the main register
//   occupancy       entries held: 0, 1 or 2
module nareg_skid #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter bit               BYPASS      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Output flags are stored alongside the state so every output comes
    // straight from a flop.
    typedef struct packed {
        logic       vld;
        logic       rdy;
        logic [1:0] occ;
    } flags_t;

    function automatic flags_t decode(input state_t s);
        flags_t f;
        case (s)
            BUSY:    f = '{vld: 1'b1, rdy: 1'b1, occ: 2'd1};
            FULL:    f = '{vld: 1'b1, rdy: 1'b0, occ: 2'd2};
            default: f = '{vld: 1'b0, rdy: 1'b1, occ: 2'd0};
        endcase
        return f;
    endfunction

    generate
        if (BYPASS) begin : g_bypass
            // Legacy holding register: loads every cycle, handshake ignored.
            logic [WIDTH-1:0] main_dat;
            logic             main_vld;
            logic             unused_out_ready;

            assign unused_out_ready = out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_dat <= RESET_VALUE;
                    main_vld <= 1'b0;
                end else begin
                    main_dat <= in_data;
                    // flush only suppresses the valid; data still loads.
                    main_vld <= in_valid & ~flush;
                end
            end

            assign in_ready  = 1'b1;
            assign out_valid = main_vld;
            assign out_data  = main_dat;
            assign occupancy = {1'b0, main_vld};
        end else begin : g_skid
            state_t           state;
            flags_t           flags;
            logic [WIDTH-1:0] main_dat;
            logic [WIDTH-1:0] skid_dat;
            logic             in_fire;
            logic             out_fire;

            assign in_fire  = in_valid & flags.rdy;
            assign out_fire = flags.vld & out_ready;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state    <= EMPTY;
                    flags    <= decode(EMPTY);
                    main_dat <= RESET_VALUE;
                    skid_dat <= RESET_VALUE;
                end else if (flush) begin
                    // Contents are discarded by state alone; out_data goes stale.
                    state <= EMPTY;
                    flags <= decode(EMPTY);
                end else begin
                    case (state)
                        EMPTY: begin
                            if (in_fire) begin
                                main_dat <= in_data;
                                state    <= BUSY;
                                flags    <= decode(BUSY);
                            end
                        end
                        BUSY: begin
                            if (in_fire && out_fire) begin
                                main_dat <= in_data;
                            end else if (in_fire) begin
                                // Consumer stalled: park the new word behind main.
                                skid_dat <= in_data;
                                state    <= FULL;
                                flags    <= decode(FULL);
                            end else if (out_fire) begin
                                state <= EMPTY;
                                flags <= decode(EMPTY);
                            end
                        end
                        FULL: begin
                            // in_ready is low here, so only the drain can happen.
                            if (out_fire) begin
                                main_dat <= skid_dat;
                                state    <= BUSY;
                                flags    <= decode(BUSY);
                            end
                        end
                        default: begin
                            state <= EMPTY;
                            flags <= decode(EMPTY);
                        end
                    endcase
                end
            end

            assign in_ready  = flags.rdy;
            assign out_valid = flags.vld;
            assign out_data  = main_dat;
            assign occupancy = flags.occ;
        end
    endgenerate

endmodule

// File: tb/tb_nareg_skid.sv
module tb_nareg_skid;

    logic        clk = 1'b0;
    logic        rst;

    // Skid-mode instance signals
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;

    // Bypass-mode instance signals
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nareg_skid #(.WIDTH(32), .RESET_VALUE(32'hDEADBEEF), .BYPASS(1'b0)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .occupancy (a_occ)
    );

    nareg_skid #(.WIDTH(32), .RESET_VALUE(32'h0), .BYPASS(1'b1)) u_byp (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .occupancy (b_occ)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk_a(input string tag, input logic vld, input logic rdy,
                         input logic [1:0] occ, input logic [31:0] dat);
        chk({tag, ".out_valid"}, {31'b0, a_out_valid}, {31'b0, vld});
        chk({tag, ".in_ready"},  {31'b0, a_in_ready},  {31'b0, rdy});
        chk({tag, ".occupancy"}, {30'b0, a_occ},       {30'b0, occ});
        chk({tag, ".out_data"},  a_out_data,           dat);
    endtask

    task automatic fill_ab;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        step();
        a_in_data   = 32'hB;
        step();
        chk_a("fill_full", 1'b1, 1'b0, 2'd2, 32'hA);
    endtask

    initial begin
        rst         = 1'b1;
        a_flush     = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush     = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk_a("reset", 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);
        chk("byp_reset.out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("byp_reset.in_ready",  {31'b0, b_in_ready},  32'd1);

        // Full-rate stream 1..8
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_in_data = i;
            step();
            chk_a($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, i);
        end
        a_in_valid = 1'b0;
        step();
        chk_a("stream_drain", 1'b0, 1'b1, 2'd0, 32'h8);

        // Stall absorbs A then B; release drains A then B
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA;
        step();
        chk_a("stall_busy", 1'b1, 1'b1, 2'd1, 32'hA);
        a_in_data = 32'hB;
        step();
        chk_a("stall_full", 1'b1, 1'b0, 2'd2, 32'hA);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        step();
        chk_a("release_b", 1'b1, 1'b1, 2'd1, 32'hB);
        step();
        chk_a("release_empty", 1'b0, 1'b1, 2'd0, 32'hB);

        // Flush while FULL drops A, B and the simultaneous C
        fill_ab();
        a_flush   = 1'b1;
        a_in_data = 32'hC;
        step();
        chk_a("flush", 1'b0, 1'b1, 2'd0, 32'hA);
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("flush_quiet%0d", i), {31'b0, a_out_valid}, 32'd0);
        end

        // Reset while FULL, then a lone push of 5
        fill_ab();
        rst        = 1'b1;
        a_in_valid = 1'b0;
        step();
        chk_a("rst_full", 1'b0, 1'b1, 2'd0, 32'hDEADBEEF);
        rst         = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h5;
        a_out_ready = 1'b1;
        step();
        chk_a("post_rst_push", 1'b1, 1'b1, 2'd1, 32'h5);
        a_in_valid = 1'b0;
        step();
        chk_a("post_rst_alone", 1'b0, 1'b1, 2'd0, 32'h5);

        // Bypass mode follows in_data one cycle late regardless of out_ready
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_in_data = 32'h11 * i;
            step();
            chk($sformatf("byp%0d.out_data", i),  b_out_data, 32'h11 * i);
            chk($sformatf("byp%0d.out_valid", i), {31'b0, b_out_valid}, 32'd1);
            chk($sformatf("byp%0d.in_ready", i),  {31'b0, b_in_ready},  32'd1);
            chk($sformatf("byp%0d.occupancy", i), {30'b0, b_occ},       32'd1);
        end
        b_in_valid = 1'b0;
        b_in_data  = 32'h44;
        step();
        chk("byp_novalid.out_data",  b_out_data, 32'h44);
        chk("byp_novalid.out_valid", {31'b0, b_out_valid}, 32'd0);
        chk("byp_novalid.occupancy", {30'b0, b_occ},       32'd0);
        b_in_valid = 1'b1;
        b_in_data  = 32'h55;
        b_flush    = 1'b1;
        step();
        chk("byp_flush.out_data",  b_out_data, 32'h55);
        chk("byp_flush.out_valid", {31'b0, b_out_valid}, 32'd0);
        b_flush = 1'b0;
        step();
        chk("byp_after_flush.out_valid", {31'b0, b_out_valid}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
